// File: rtl/fnd_scan_rx_pkg.sv
// Shared constants for the 7-segment scan receiver: segment patterns, digit codes,
// frame FSM encoding and the BCD-pair to binary helper.
package fnd_scan_rx_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    // Tens/ones pair to binary; any non-decimal digit or a sum above 63 saturates.
    function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] sum;
        if (tens > 4'd9 || ones > 4'd9) return 6'd63;
        sum = {3'b000, tens} * 7'd10 + {3'b000, ones};
        return (sum > 7'd63) ? 6'd63 : sum[5:0];
    endfunction

endpackage

// File: rtl/fnd_scan_rx_seg_dec.sv
// fnd_seg_dec: combinational segment pattern to digit decoder with a valid flag;
// unrecognized patterns (including blank) give DIGIT_BLANK with valid low.
module fnd_seg_dec
    import fnd_scan_rx_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    // NOTE: both outputs get a default before the case so no path can infer a latch.
    always_comb begin
        digit = DIGIT_BLANK;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/fnd_scan_rx.sv
// Scan-bus receiver: synchronizes the digit enables/segments, captures each digit after
// a dwell period and commits complete six-digit frames. FND_SCAN_RX_BIN_EN adds o_sec/o_min.
module fnd_scan_rx
    import fnd_scan_rx_pkg::*;
#(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  i_seg_enb,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic        o_frame_vld,
    output logic        o_scan_err
);

    localparam int CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] DWELL_MAX = CW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC - 1);
    localparam logic [13:0]   SYNC_RST  = {6'h3F, 8'h00};

    // Bus packed as {enb, seg, dp}; the idle bus has all enables high.
    logic [13:0] sync1, sync2, prev_q;
    logic [CW-1:0] dwell_cnt;
    logic          cap_flag;

    logic [5:0] cur_enb, enb_low;
    logic [6:0] cur_seg;
    logic       cur_dp, enb_ok, stable, capture;
    logic [2:0] cur_idx;
    logic [3:0] dec_digit;
    logic       dec_valid;

    assign cur_enb = sync2[13:8];
    assign cur_seg = sync2[7:1];
    assign cur_dp  = sync2[0];
    assign enb_low = ~cur_enb;
    assign enb_ok  = (enb_low != 6'd0) && ((enb_low & (enb_low - 6'd1)) == 6'd0);
    assign stable  = (sync2 == prev_q);
    assign capture = enb_ok && stable && !cap_flag && (dwell_cnt == DWELL_MAX);

    always_comb begin
        cur_idx = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (enb_low[k]) cur_idx = 3'(k);
    end

    fnd_seg_dec u_dec (
        .seg   (cur_seg),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= SYNC_RST;
            sync2     <= SYNC_RST;
            prev_q    <= SYNC_RST;
            dwell_cnt <= '0;
            cap_flag  <= 1'b0;
        end else begin
            sync1  <= {i_seg_enb, i_seg, i_seg_dp};
            sync2  <= sync1;
            prev_q <= sync2;
            if (!enb_ok || !stable)
                dwell_cnt <= '0;
            else if (dwell_cnt != DWELL_MAX)
                dwell_cnt <= dwell_cnt + 1'b1;
            if (cur_enb != prev_q[13:8])
                cap_flag <= 1'b0;
            else if (capture)
                cap_flag <= 1'b1;
        end
    end

    logic       cap_vld_q, cap_dp_q;
    logic [2:0] cap_idx_q;
    logic [3:0] cap_digit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= 3'd0;
            cap_digit_q <= DIGIT_BLANK;
            cap_dp_q    <= 1'b0;
        end else begin
            cap_vld_q <= capture;
            if (capture) begin
                cap_idx_q   <= cur_idx;
                cap_digit_q <= dec_valid ? dec_digit : DIGIT_BLANK;
                cap_dp_q    <= cur_dp;
            end
        end
    end

    state_t                         state;
    logic [2:0]                     exp_idx;
    logic [TW-1:0]                  to_cnt;
    logic [NUM_DIGITS-1:0][3:0]     shadow_digits, frame_digits;
    logic [NUM_DIGITS-1:0]          shadow_dp, frame_dp;

    // The frame being committed is the shadow buffer plus the digit-5 capture in flight.
    always_comb begin
        frame_digits    = shadow_digits;
        frame_digits[5] = cap_digit_q;
        frame_dp        = shadow_dp;
        frame_dp[5]     = cap_dp_q;
    end

    // NOTE: the small shadow buffer is reset so a partial frame never leaks past a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            exp_idx       <= 3'd0;
            to_cnt        <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            o_digits      <= 24'hFFFFFF;
            o_dp          <= '0;
            o_frame_vld   <= 1'b0;
            o_scan_err    <= 1'b0;
`ifdef FND_SCAN_RX_BIN_EN
            o_sec         <= '0;
            o_min         <= '0;
`endif
        end else begin
            o_frame_vld <= 1'b0;
            o_scan_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (cap_vld_q && cap_idx_q == 3'd0) begin
                        shadow_digits[0] <= cap_digit_q;
                        shadow_dp[0]     <= cap_dp_q;
                        exp_idx          <= 3'd1;
                        state            <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cap_vld_q) begin
                        to_cnt <= '0;
                        if (cap_idx_q == exp_idx) begin
                            shadow_digits[cap_idx_q] <= cap_digit_q;
                            shadow_dp[cap_idx_q]     <= cap_dp_q;
                            if (exp_idx == 3'(NUM_DIGITS - 1)) begin
                                o_digits    <= frame_digits;
                                o_dp        <= frame_dp;
                                o_frame_vld <= 1'b1;
`ifdef FND_SCAN_RX_BIN_EN
                                o_sec       <= to_bin(frame_digits[1], frame_digits[0]);
                                o_min       <= to_bin(frame_digits[3], frame_digits[2]);
`endif
                                state       <= ST_IDLE;
                            end else begin
                                exp_idx <= exp_idx + 3'd1;
                            end
                        end else begin
                            o_scan_err <= 1'b1;
                            if (cap_idx_q == 3'd0) begin
                                shadow_digits[0] <= cap_digit_q;
                                shadow_dp[0]     <= cap_dp_q;
                                exp_idx          <= 3'd1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end else if (to_cnt == TO_MAX) begin
                        o_scan_err <= 1'b1;
                        to_cnt     <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef FND_SCAN_RX_BIN_EN
    assign o_sec = 6'd0;
    assign o_min = 6'd0;
`endif

endmodule
